lcg_stim_gen: RTL and testbench
===============================

Name: lcg_stim_gen

Overview:
Synthesizable, parametrised successor to the fuzz-bench LCG input driver. Generates OUT_W-bit stimulus vectors from the shared 32-bit LCG (x' = x*0x41C64E6D + 0x3039) and assembles each vector one 32-bit word per clock. Vectors are presented over a valid/ready interface. Adds run control (start/abort/done), a programmable vector count, and three modes (random, hold, walking-one), so on-chip or emulation fuzz harnesses can drive a DUT's in_flat with no testbench code.

Parameters:
OUT_W, 261, stimulus vector width (>=1)
SEED, 32'd2343292475, LCG state after reset
CNT_W, 32, width of vector counter and num_vectors

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin run; accepted only in IDLE or DONE
abort  in  1  return to IDLE at next edge, priority over everything except rst
mode  in  2  0=RANDOM, 1=HOLD, 2=WALK, 3=reserved (treated as RANDOM); sampled on accepted start
seed_load  in  1  on accepted start, load lcg state from seed_i
seed_i  in  32  seed value
num_vectors  in  CNT_W  vectors to emit per run; sampled on accepted start
out_valid  out  1  out_data holds a complete vector
out_ready  in  1  consumer accepts
out_data  out  OUT_W  stimulus vector
vec_count  out  CNT_W  vectors accepted in current run
busy  out  1  state is FILL or PRESENT
done  out  1  high in DONE until next start/abort

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE, lcg=SEED, out_valid=0, out_data=0, vec_count=0, done=0, busy=0, word index k=0.
- NWORDS = ceil(OUT_W/32). Word k fills out_data[32k +: 32]. The final word is truncated to its low OUT_W-32*(NWORDS-1) bits.
- IDLE/DONE + start:
  - if seed_load, lcg<=seed_i.
  - vec_count<=0, done<=0, k<=0.
  - num_vectors==0: go to DONE, done=1 the next cycle. Otherwise go to FILL.
- FILL, RANDOM mode: each cycle lcg<=step(lcg) and word k<=step(lcg), so the stepped value is used, as the bench driver does. After word NWORDS-1, go to PRESENT. Latency from start to out_valid = NWORDS+1 cycles.
- FILL, HOLD mode: only the first vector is filled as in RANDOM. Later vectors are not refilled.
- FILL, WALK mode: one cycle. out_data <= 1 << (vec_count mod OUT_W). LCG is not stepped.
- PRESENT: out_valid=1, and out_data is stable while out_valid && !out_ready. On handshake:
  - vec_count++.
  - If vec_count+1 == num_vectors: go to DONE, out_valid=0.
  - Else RANDOM/WALK: go to FILL (out_valid=0 during FILL).
  - Else HOLD: stay in PRESENT with out_valid=1 and data unchanged, giving 1 vector/cycle.
- out_data keeps its last value in DONE/IDLE. It is never cleared except by rst.
- start in FILL/PRESENT is ignored.
- abort in any state: IDLE next cycle, out_valid=0, done=0. lcg and out_data are kept.
- rst mid-run: full reset values, with lcg=SEED (not seed_i).
- vec_count wraps at 2^CNT_W. num_vectors is compared for equality only.
- All arithmetic on lcg is modulo 2^32.

Optional Feature:
LCG_STIM_CHECKSUM_EN
- Defined: adds output port chksum [31:0]. It resets to 0 and clears on accepted start. On each handshake it updates to chksum ^ (XOR of all 32-bit words of out_data, last word zero-extended). This lets a harness confirm the stimulus stream cross-simulator in one word.
- Undefined: no port and no logic.

Decomposition:
- Package lcg_stim_pkg holds:
  - LCG_MUL=32'h41C64E6D and LCG_INC=32'h3039.
  - mode_e enum {MODE_RANDOM, MODE_HOLD, MODE_WALK}.
  - state_e enum {S_IDLE, S_FILL, S_PRESENT, S_DONE}.
  - function lcg_step.
- One sub-module, lcg32_core: 32-bit state register with load/step enables and a next-value output. The top module holds the FSM, the word assembler and the counters.

Test Plan:
- OUT_W=64, seed_load=1, seed_i=0, RANDOM, num_vectors=1, out_ready=1 → out_valid rises 3 cycles after start with out_data=64'hD3DC167E_00003039, then done=1 and vec_count=1.
- Reset defaults with OUT_W=261, RANDOM, num_vectors=3, out_ready held 0 for 5 cycles → out_data stable while stalled. The first vector's low word equals lcg_step(2343292475), and the stream matches a reference model of the bench LCG for all 3 vectors.
- HOLD, num_vectors=4, out_ready=1 → 4 identical vectors on consecutive cycles after the single fill, then done.
- WALK, OUT_W=8, num_vectors=10 → out_data sequence 01,02,04,…,80,01,02, with each vector preceded by a 1-cycle fill bubble.
- num_vectors=0 → done=1 one cycle after start and out_valid is never asserted. Then abort mid-FILL of a new run → IDLE next cycle, out_valid=0, and a new start is accepted.
- With LCG_STIM_CHECKSUM_EN, OUT_W=64, seed_i=0, num_vectors=1 → chksum=32'hD3DC2647.

Source files
------------

// File: rtl/lcg_stim_pkg.sv
// Shared types, constants and the LCG step function for the stimulus generator.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_WALK   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  // One LCG step, modulo 2^32.
  function automatic logic [31:0] lcg_step(input logic [31:0] x);
    return x * LCG_MUL + LCG_INC;
  endfunction

endpackage

// File: rtl/lcg_stim_gen_lcg32_core.sv
// 32-bit LCG state register with load and step enables; exposes the stepped value.
module lcg32_core
  import lcg_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd2343292475
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] next
);

  logic [31:0] state;

  assign next = lcg_step(state);

  // State register: reset to SEED, load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= next;
    end
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: assembles OUT_W-bit vectors one 32-bit word per clock
// and presents them over valid/ready, with run control and three fill modes.
// Optional feature macro: LCG_STIM_CHECKSUM_EN adds the chksum output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start (after reset or abort)
// S_FILL    | building the next vector (NWORDS cycles, or 1 in WALK)
// S_PRESENT | out_valid high, waiting for out_ready
// S_DONE    | run complete, done high, waiting for start
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int          OUT_W = 261,
  parameter logic [31:0] SEED  = 32'd2343292475,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic             seed_load,
  input  logic [31:0]      seed_i,
  input  logic [CNT_W-1:0] num_vectors,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] vec_count,
  output logic             busy,
  output logic             done
`ifdef LCG_STIM_CHECKSUM_EN
  ,
  output logic [31:0]      chksum
`endif
);

  localparam int NWORDS = (OUT_W + 31) / 32;
  localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  state_e           state, state_n;
  mode_e            mode_q, mode_dec;
  logic [CNT_W-1:0] nvec_q;
  logic [KW-1:0]    k;
  logic             k_last;
  logic [31:0]      lcg_next;
  logic             lcg_load, lcg_step_en;
  logic             start_ok, fill_we, walk_we, hs;
  logic [OUT_W-1:0] fill_vec, walk_vec;
  logic [CNT_W-1:0] walk_idx;

  lcg32_core #(.SEED(SEED)) u_lcg (
    .clk      (clk),
    .rst      (rst),
    .load     (lcg_load),
    .load_val (seed_i),
    .step     (lcg_step_en),
    .next     (lcg_next)
  );

  assign out_valid = (state == S_PRESENT);
  assign busy      = (state == S_FILL) || (state == S_PRESENT);
  assign done      = (state == S_DONE);
  assign k_last    = (int'(k) == NWORDS - 1);

  // Reserved mode encoding falls back to RANDOM.
  always_comb begin
    mode_dec = MODE_RANDOM;
    case (mode)
      2'd1:    mode_dec = MODE_HOLD;
      2'd2:    mode_dec = MODE_WALK;
      default: mode_dec = MODE_RANDOM;
    endcase
  end

  // Current vector with word k replaced by the stepped LCG value; bits past
  // OUT_W in the last word are simply never written.
  always_comb begin
    fill_vec = out_data;
    for (int j = 0; j < OUT_W; j++) begin
      if ((j / 32) == int'(k)) fill_vec[j] = lcg_next[j % 32];
    end
  end

  // Walking-one vector positioned by the accepted-vector count.
  always_comb begin
    walk_idx = vec_count % CNT_W'(OUT_W);
    walk_vec = OUT_W'(1) << walk_idx;
  end

  // Next-state and per-cycle enables; abort overrides every transition.
  always_comb begin
    state_n     = state;
    lcg_load    = 1'b0;
    lcg_step_en = 1'b0;
    start_ok    = 1'b0;
    fill_we     = 1'b0;
    walk_we     = 1'b0;
    hs          = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            start_ok = 1'b1;
            lcg_load = seed_load;
            state_n  = (num_vectors == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (mode_q == MODE_WALK) begin
            walk_we = 1'b1;
            state_n = S_PRESENT;
          end else begin
            lcg_step_en = 1'b1;
            fill_we     = 1'b1;
            if (k_last) state_n = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            hs = 1'b1;
            if ((vec_count + CNT_W'(1)) == nvec_q) begin
              state_n = S_DONE;
            end else if (mode_q != MODE_HOLD) begin
              state_n = S_FILL;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, run configuration, word index, vector register and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= MODE_RANDOM;
      nvec_q    <= '0;
      vec_count <= '0;
      k         <= '0;
      out_data  <= '0;
    end else begin
      state <= state_n;
      if (start_ok) begin
        mode_q    <= mode_dec;
        nvec_q    <= num_vectors;
        vec_count <= '0;
        k         <= '0;
      end
      if (fill_we) begin
        out_data <= fill_vec;
        k        <= k_last ? '0 : k + KW'(1);
      end
      if (walk_we) out_data <= walk_vec;
      if (hs) vec_count <= vec_count + CNT_W'(1);
    end
  end

`ifdef LCG_STIM_CHECKSUM_EN
  logic [31:0] cs_word;

  // XOR fold of the presented vector into one 32-bit word.
  always_comb begin
    cs_word = '0;
    for (int j = 0; j < OUT_W; j++) begin
      cs_word[j % 32] = cs_word[j % 32] ^ out_data[j];
    end
  end

  // Running checksum of accepted vectors, cleared at each run start.
  always_ff @(posedge clk) begin
    if (rst) begin
      chksum <= '0;
    end else if (start_ok) begin
      chksum <= '0;
    end else if (hs) begin
      chksum <= chksum ^ cs_word;
    end
  end
`endif

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Self-checking bench for lcg_stim_gen: three widths (64, 261, 8) share stimulus;
// a table of runs is scored against a reference LCG model via a queue.
module tb_lcg_stim_gen;

  localparam logic [31:0] SEED = 32'd2343292475;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, seed_load, out_ready;
  logic [1:0]  mode;
  logic [31:0] seed_i, num_vectors;

  logic         v0, v1, v2, b0, b1, b2, dn0, dn1, dn2;
  logic [63:0]  d0;
  logic [260:0] d1;
  logic [7:0]   d2;
  logic [31:0]  c0, c1, c2;
`ifdef LCG_STIM_CHECKSUM_EN
  logic [31:0]  cs0, cs1, cs2;
`endif

  lcg_stim_gen #(.OUT_W(64), .SEED(SEED), .CNT_W(32)) u_w64 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .seed_load(seed_load), .seed_i(seed_i), .num_vectors(num_vectors),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0), .vec_count(c0),
    .busy(b0), .done(dn0)
`ifdef LCG_STIM_CHECKSUM_EN
    , .chksum(cs0)
`endif
  );

  lcg_stim_gen #(.OUT_W(261), .SEED(SEED), .CNT_W(32)) u_w261 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .seed_load(seed_load), .seed_i(seed_i), .num_vectors(num_vectors),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1), .vec_count(c1),
    .busy(b1), .done(dn1)
`ifdef LCG_STIM_CHECKSUM_EN
    , .chksum(cs1)
`endif
  );

  lcg_stim_gen #(.OUT_W(8), .SEED(SEED), .CNT_W(32)) u_w8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .seed_load(seed_load), .seed_i(seed_i), .num_vectors(num_vectors),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2), .vec_count(c2),
    .busy(b2), .done(dn2)
`ifdef LCG_STIM_CHECKSUM_EN
    , .chksum(cs2)
`endif
  );

  // Monitor mux: which instance the current run is scored on.
  int           sel;
  logic         m_valid, m_busy, m_done;
  logic [260:0] m_data;
  logic [31:0]  m_cnt;
  always_comb begin
    m_valid = v1; m_busy = b1; m_done = dn1; m_data = d1; m_cnt = c1;
    case (sel)
      0: begin m_valid = v0; m_busy = b0; m_done = dn0; m_data = 261'(d0); m_cnt = c0; end
      2: begin m_valid = v2; m_busy = b2; m_done = dn2; m_data = 261'(d2); m_cnt = c2; end
      default: ;
    endcase
  end

  int widths [0:2] = '{64, 261, 8};
  int checks = 0;
  int errors = 0;
  logic [260:0] sb [$];
  logic [31:0]  m_lcg;

  typedef struct {
    int          sel;
    logic [1:0]  mode;
    logic        sl;
    logic [31:0] seed;
    int          nvec;
  } run_t;

  run_t tbl [0:6];

  task automatic check(input string nm, input logic [260:0] act, input logic [260:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] x);
    return x * 32'h41C64E6D + 32'h3039;
  endfunction

  task automatic model_random(input int w, output logic [260:0] v);
    logic [31:0] wd [0:8];
    int nw;
    nw = (w + 31) / 32;
    for (int i = 0; i < nw; i++) begin
      m_lcg = ref_step(m_lcg);
      wd[i] = m_lcg;
    end
    v = '0;
    for (int j = 0; j < w; j++) v[j] = wd[j / 32][j % 32];
  endtask

  task automatic push_expected(input logic [1:0] md, input int w, input int nvec);
    logic [260:0] v;
    v = '0;
    if (md == 2'd2) begin
      for (int i = 0; i < nvec; i++) begin
        v = '0;
        v[i % w] = 1'b1;
        sb.push_back(v);
      end
    end else if (md == 2'd1) begin
      if (nvec > 0) model_random(w, v);
      for (int i = 0; i < nvec; i++) sb.push_back(v);
    end else begin
      for (int i = 0; i < nvec; i++) begin
        model_random(w, v);
        sb.push_back(v);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_lcg = SEED;
    sb.delete();
  endtask

  // Runs cycles until done, scoring each handshake; cyc counts edges since start.
  task automatic drain(input string nm, inout int cyc, output int seen);
    logic [260:0] e;
    seen = 0;
    while (!m_done && cyc < 400) begin
      if (m_valid && out_ready) begin
        seen++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s_extra: got unexpected vector %h", nm, m_data);
        end else begin
          e = sb.pop_front();
          check(nm, m_data, e);
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 400) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", nm, cyc);
    end
  endtask

  task automatic run(input run_t t, input string nm);
    int cyc, seen, nw, exp_cyc;
    sel = t.sel;
    nw  = (widths[t.sel] + 31) / 32;
    if (t.sl) m_lcg = t.seed;
    push_expected(t.mode, widths[t.sel], t.nvec);
    if (t.nvec == 0)         exp_cyc = 1;
    else if (t.mode == 2'd2) exp_cyc = 1 + 2 * t.nvec;
    else if (t.mode == 2'd1) exp_cyc = 1 + nw + t.nvec;
    else                     exp_cyc = 1 + t.nvec * (nw + 1);
    @(negedge clk);
    mode = t.mode; seed_load = t.sl; seed_i = t.seed;
    num_vectors = t.nvec; out_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    drain(nm, cyc, seen);
    check({nm, "_cycles"}, cyc, exp_cyc);
    check({nm, "_seen"}, seen, t.nvec);
    check({nm, "_vec_count"}, m_cnt, t.nvec);
    check({nm, "_sb_empty"}, sb.size(), 0);
    check({nm, "_valid_low"}, m_valid, 0);
  endtask

  initial begin
    int cyc, seen;
    logic [260:0] e;
    run_t t;
    sel = 1; rst = 1'b1; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    out_ready = 1'b0; mode = 2'd0; seed_i = '0; num_vectors = '0;

    tbl[0] = '{sel: 0, mode: 2'd0, sl: 1'b1, seed: 32'h0,        nvec: 1};
    tbl[1] = '{sel: 1, mode: 2'd0, sl: 1'b0, seed: 32'h0,        nvec: 3};
    tbl[2] = '{sel: 0, mode: 2'd1, sl: 1'b1, seed: 32'h12345678, nvec: 4};
    tbl[3] = '{sel: 2, mode: 2'd2, sl: 1'b0, seed: 32'h0,        nvec: 10};
    tbl[4] = '{sel: 1, mode: 2'd3, sl: 1'b1, seed: 32'hDEADBEEF, nvec: 2};
    tbl[5] = '{sel: 2, mode: 2'd0, sl: 1'b1, seed: 32'hCAFEF00D, nvec: 5};
    tbl[6] = '{sel: 1, mode: 2'd0, sl: 1'b0, seed: 32'h0,        nvec: 0};

    do_reset();
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_vec_count", m_cnt, 0);
    check("rst_done", m_done, 0);
    check("rst_busy", m_busy, 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run(tbl[i], $sformatf("run%0d", i));
      if (i == 0) begin
        check("w64_seed0_data", 261'(d0), 261'(64'hD3DC167E_00003039));
`ifdef LCG_STIM_CHECKSUM_EN
        check("w64_seed0_chksum", cs0, 32'hD3DC2647);
`endif
      end
    end

    // Abort mid-FILL after the empty run, then restart from IDLE.
    sel = 1;
    @(negedge clk);
    mode = 2'd0; seed_load = 1'b1; seed_i = 32'h5; num_vectors = 2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_pre_busy", m_busy, 1);
    check("abort_pre_done", m_done, 0);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", m_valid, 0);
    check("abort_done", m_done, 0);
    check("abort_busy", m_busy, 0);
    t = '{sel: 0, mode: 2'd0, sl: 1'b1, seed: 32'h0, nvec: 1};
    run(t, "after_abort");

    // Stall with out_ready low: data held, start ignored, then drain.
    do_reset();
    sel = 1;
    for (int i = 0; i < 3; i++) begin
      model_random(261, e);
      sb.push_back(e);
    end
    @(negedge clk);
    mode = 2'd0; seed_load = 1'b0; num_vectors = 3; out_ready = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!m_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("stall_latency", cyc, 10);
    check("stall_low_word", m_data[31:0], ref_step(SEED));
    for (int s = 0; s < 5; s++) begin
      start = (s == 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, sb[0]);
      check("stall_vec_count", m_cnt, 0);
    end
    out_ready = 1'b1;
    drain("stall_drain", cyc, seen);
    check("stall_seen", seen, 3);
    check("stall_done", m_done, 1);
    check("stall_vec_final", m_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
